// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_subtractor_pkg: FSM state encoding shared by the subtractor. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package serial_subtractor_pkg;

   localparam int SS_STATE_W = 2;

   localparam logic [SS_STATE_W-1:0] SS_IDLE = 2'd0;
   localparam logic [SS_STATE_W-1:0] SS_BUSY = 2'd1;
   localparam logic [SS_STATE_W-1:0] SS_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_subtractor_if: start/done handshake, operands and results.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface serial_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             overflow;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow, overflow
   );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor_fa.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_subtractor_fa: 1-bit full adder used as the bit-slice.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module serial_subtractor_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ c_i;
   assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_subtractor: bit-serial A - B, LSB first, one bit per clock.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_subtractor_if.slave bus_if
);
   localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   logic [SS_STATE_W-1:0] state_q, state_d;
   logic [WIDTH-1:0]      a_sr_q, a_sr_d;
   logic [WIDTH-1:0]      b_sr_q, b_sr_d;
   logic [WIDTH-1:0]      res_sr_q, res_sr_d;
   logic [WIDTH-1:0]      diff_q, diff_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  carry_q, carry_d;
   logic                  a_msb_q, a_msb_d;
   logic                  b_msb_q, b_msb_d;
   logic                  borrow_q, borrow_d;
   logic                  ovf_q, ovf_d;
   logic                  fa_sum;
   logic                  fa_cout;

   // Subtract as a + ~b + 1: subtrahend bit inverted, carry flop seeded with 1.
   serial_subtractor_fa u_fa (
      .a_i  (a_sr_q[0]),
      .b_i  (~b_sr_q[0]),
      .c_i  (carry_q),
      .s_o  (fa_sum),
      .co_o (fa_cout)
   );

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      res_sr_d = res_sr_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      case (state_q)
         SS_IDLE: begin
            if (bus_if.start) begin
               a_sr_d  = bus_if.a;
               b_sr_d  = bus_if.b;
               a_msb_d = bus_if.a[WIDTH-1];
               b_msb_d = bus_if.b[WIDTH-1];
               carry_d = 1'b1;
               cnt_d   = '0;
               state_d = SS_BUSY;
            end
         end
         SS_BUSY: begin
            res_sr_d = {fa_sum, res_sr_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               diff_d   = {fa_sum, res_sr_q[WIDTH-1:1]};
               borrow_d = ~fa_cout;
               ovf_d    = (a_msb_q ^ b_msb_q) & (fa_sum ^ a_msb_q);
               state_d  = SS_DONE;
            end
         end
         SS_DONE: state_d = SS_IDLE;
         default: state_d = SS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= SS_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         res_sr_q <= res_sr_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus_if.busy     = (state_q == SS_BUSY);
   assign bus_if.done     = (state_q == SS_DONE);
   assign bus_if.diff     = diff_q;
   assign bus_if.borrow   = borrow_q;
   assign bus_if.overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_serial_subtractor: directed bench for WIDTH=4 and WIDTH=8 DUTs.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_serial_subtractor;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_subtractor_if #(.WIDTH(4)) if4 ();
   serial_subtractor_if #(.WIDTH(8)) if8 ();

   serial_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus_if(if4));
   serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus_if(if8));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=4 operation from IDLE: latency, results, return to IDLE.
   task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] ed, input logic eb, input logic eo);
      int lat;
      if4.start = 1'b1; if4.a = a; if4.b = b;
      step();
      if4.start = 1'b0; if4.a = ~a; if4.b = ~b;
      chk({tag, "_busy"}, {31'd0, if4.busy}, 32'd1);
      lat = 0;
      while (!if4.done && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, lat, 32'd4);
      chk({tag, "_diff"}, {28'd0, if4.diff}, {28'd0, ed});
      chk({tag, "_borrow"}, {31'd0, if4.borrow}, {31'd0, eb});
      chk({tag, "_ovf"}, {31'd0, if4.overflow}, {31'd0, eo});
      step();
      chk({tag, "_done_pulse"}, {31'd0, if4.done}, 32'd0);
   endtask

   initial begin
      logic [7:0] vals [16];
      int         dones;
      int         prev;
      int         n;
      logic [7:0] xa, xb, ed8;
      int         sr;

      if4.start = 1'b0; if4.a = '0; if4.b = '0;
      if8.start = 1'b0; if8.a = '0; if8.b = '0;
      step(); step();
      chk("rst_busy",   {31'd0, if4.busy},     32'd0);
      chk("rst_done",   {31'd0, if4.done},     32'd0);
      chk("rst_diff",   {28'd0, if4.diff},     32'd0);
      chk("rst_borrow", {31'd0, if4.borrow},   32'd0);
      chk("rst_ovf",    {31'd0, if4.overflow}, 32'd0);
      rst_n = 1'b1;
      step();

      // Signed overflow by definition: 9-3 is -7-3, 3-9 is 3-(-7); both overflow.
      op4("t1", 4'd9, 4'd3, 4'h6, 1'b0, 1'b1);
      op4("t2", 4'd3, 4'd9, 4'hA, 1'b1, 1'b1);
      op4("t3a", 4'h8, 4'h1, 4'h7, 1'b0, 1'b1);
      op4("t3b", 4'h7, 4'hF, 4'h8, 1'b1, 1'b1);
      op4("bnd_eq", 4'hB, 4'hB, 4'h0, 1'b0, 1'b0);
      op4("bnd_b0", 4'hD, 4'h0, 4'hD, 1'b0, 1'b0);
      op4("bnd_01", 4'h0, 4'h1, 4'hF, 1'b1, 1'b0);

      // Start held through BUSY and DONE with changing operands must be ignored.
      if4.start = 1'b1; if4.a = 4'd5; if4.b = 4'd2;
      step();
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         if4.a = 4'(i); if4.b = 4'(i + 3);
         if (if4.done) dones++;
         step();
      end
      if4.start = 1'b0;
      chk("t4_dones", dones, 32'd1);
      chk("t4_diff", {28'd0, if4.diff}, 32'd3);
      chk("t4_no_restart", {31'd0, if4.busy}, 32'd0);
      step();
      chk("t4_idle", {31'd0, if4.busy | if4.done}, 32'd0);

      // Reset during the second BUSY cycle aborts and clears results.
      if4.start = 1'b1; if4.a = 4'd12; if4.b = 4'd4;
      step();
      if4.start = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t5_busy",   {31'd0, if4.busy},     32'd0);
      chk("t5_done",   {31'd0, if4.done},     32'd0);
      chk("t5_diff",   {28'd0, if4.diff},     32'd0);
      chk("t5_borrow", {31'd0, if4.borrow},   32'd0);
      chk("t5_ovf",    {31'd0, if4.overflow}, 32'd0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (if4.done) dones++;
      end
      chk("t5_no_done", dones, 32'd0);
      op4("t5_new", 4'd1, 4'd1, 4'h0, 1'b0, 1'b0);
      op4("t5_hold", 4'd2, 4'd7, 4'hB, 1'b1, 1'b0);

      // WIDTH=8 grid sweep with start held high: one op every 10 cycles.
      vals = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h0F, 8'h3C, 8'h55, 8'h7E,
               8'h7F, 8'h80, 8'h81, 8'hA5, 8'hC3, 8'hF0, 8'hFE, 8'hFF};
      prev = -1;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            xa = vals[i]; xb = vals[j];
            if8.start = 1'b1; if8.a = xa; if8.b = xb;
            n = 0;
            while (!if8.busy && n < 30) begin
               step();
               n++;
            end
            if8.a = ~xa; if8.b = xb ^ 8'h5A;
            if (prev >= 0) chk("w8_period", cyc - prev, 32'd10);
            prev = cyc;
            n = 0;
            while (!if8.done && n < 30) begin
               step();
               n++;
            end
            ed8 = xa - xb;
            sr  = int'($signed(xa)) - int'($signed(xb));
            chk($sformatf("w8_diff_%02h_%02h", xa, xb), {24'd0, if8.diff}, {24'd0, ed8});
            chk($sformatf("w8_borrow_%02h_%02h", xa, xb), {31'd0, if8.borrow},
                (xa < xb) ? 32'd1 : 32'd0);
            chk($sformatf("w8_ovf_%02h_%02h", xa, xb), {31'd0, if8.overflow},
                (sr > 127 || sr < -128) ? 32'd1 : 32'd0);
         end
      end
      if8.start = 1'b0;
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
